// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared definitions for the ALU arbiter. This package holds the
//               opcode constants, the instruction field positions, the
//               sequencer state encoding and the result sanitiser.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

  localparam int INST_W = 19;
  localparam int DATA_W = 16;

  // Instruction layout: {opcode[2:0], op1[7:0], op2[7:0]}
  localparam int OPC_HI = 18;
  localparam int OPC_LO = 16;
  localparam int OP1_HI = 15;
  localparam int OP1_LO = 8;
  localparam int OP2_HI = 7;
  localparam int OP2_LO = 0;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Every opcode above OR is reserved.
  function automatic logic is_legal(input logic [2:0] opc);
    return (opc <= OP_OR);
  endfunction

  // The ALU leaves stale upper bits for the logical ops, so only the low
  // byte of those results is meaningful.
  function automatic logic [DATA_W-1:0] sanitise(input logic [2:0]        opc,
                                                 input logic [DATA_W-1:0] res);
    if ((opc == OP_AND) || (opc == OP_OR)) begin
      return {8'h00, res[7:0]};
    end
    return res;
  endfunction

endpackage : alu_arbiter_pkg
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant logic. A lone requester is granted
//               directly; when both request, the port held in the priority
//               register wins, and on every accept the priority moves to the
//               other port, so simultaneous requesters alternate strictly.
// Ports       : clk      - clock
//               rst_n    - synchronous active-low reset (priority -> port 0)
//               i_req    - per-port request
//               i_accept - a grant was taken this cycle; advance priority
//               o_grant  - index of the granted port
//               o_any    - at least one port is requesting
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic       o_grant,
  output logic       o_any
);

  logic r_prio;
  logic w_grant;

  // With a single requester the grant is simply that port's index.
  assign w_grant = (i_req == 2'b11) ? r_prio : i_req[1];
  assign o_grant = w_grant;
  assign o_any   = |i_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (i_accept) begin
      r_prio <= ~w_grant;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-port request arbiter and sequencer for the shared 8-bit
//               ALU. It accepts one instruction at a time (round-robin),
//               drives it into the external ALU, captures and sanitises the
//               registered result and returns it to the owning requester.
// Ports       : clk, rst_n            - clock, synchronous active-low reset
//               req_valid/req_ready   - per-port request handshake
//               req_inst0/req_inst1   - per-port 19-bit instruction
//               rsp_valid/rsp_ready   - per-port response handshake
//               rsp_data, rsp_err     - shared result and illegal-op flag
//               alu_inst, alu_r       - external ALU instruction / result
//               busy                  - sequencer is not IDLE
//               ops_done              - completed-response counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [18:0]      req_inst0,
  input  logic [18:0]      req_inst1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             rsp_err,
  output logic [18:0]      alu_inst,
  input  logic [15:0]      alu_r,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_owner;
  logic [2:0]         r_opc;
  logic [18:0]        r_alu_inst;
  logic [15:0]        r_data;
  logic               r_err;
  logic [CNT_W-1:0]   r_ops;

  logic               w_grant;
  logic               w_any;
  logic               w_accept;
  logic               w_legal;
  logic               w_rsp_hs;
  logic [18:0]        w_inst;
  logic [1:0]         w_req_ready;
  logic [1:0]         w_rsp_valid;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant),
    .o_any    (w_any)
  );

  assign w_inst   = w_grant ? req_inst1 : req_inst0;
  assign w_legal  = is_legal(w_inst[OPC_HI:OPC_LO]);
  assign w_accept = (r_state == IDLE) && w_any;
  assign w_rsp_hs = (r_state == RESP) && rsp_ready[r_owner];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 2'b00;
    w_rsp_valid = 2'b00;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_req_ready[w_grant] = 1'b1;
          // Illegal opcodes skip the ALU and answer straight away.
          w_state_nxt = w_legal ? EXEC : RESP;
        end
      end
      EXEC: w_state_nxt = CAPT;
      CAPT: w_state_nxt = RESP;
      RESP: begin
        w_rsp_valid[r_owner] = 1'b1;
        if (rsp_ready[r_owner]) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner    <= 1'b0;
      r_opc      <= OP_ADD;
      r_alu_inst <= '0;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_ops      <= '0;
    end else begin
      if (w_accept) begin
        r_owner <= w_grant;
        r_opc   <= w_inst[OPC_HI:OPC_LO];
        r_err   <= ~w_legal;
        if (w_legal) begin
          r_alu_inst <= {w_inst[OPC_HI:OPC_LO], w_inst[OP1_HI:OP1_LO],
                         w_inst[OP2_HI:OP2_LO]};
        end else begin
          r_data <= '0;
        end
      end
      if (r_state == CAPT) begin
        r_data <= sanitise(r_opc, alu_r);
      end
      if (w_rsp_hs) begin
        r_ops <= r_ops + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Ready is masked while reset is asserted so no upstream handshake can
  // complete on the same edge that discards it.
  assign req_ready = rst_n ? w_req_ready : 2'b00;
  assign rsp_valid = w_rsp_valid;
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;
  assign alu_inst  = r_alu_inst;
  assign busy      = (r_state != IDLE);
  assign ops_done  = r_ops;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. It contains an external
//               ALU model, a transaction-level reference model checked every
//               cycle, and directed tests with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  // A narrow counter makes the wrap-around reachable in a short run.
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [18:0]   req_inst0;
  logic [18:0]   req_inst1;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [15:0]   rsp_data;
  logic          rsp_err;
  logic [18:0]   alu_inst;
  logic [15:0]   alu_r = 16'h0000;
  logic          busy;
  logic [CW-1:0] ops_done;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_inst0 (req_inst0),
    .req_inst1 (req_inst1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .alu_inst  (alu_inst),
    .alu_r     (alu_r),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  // External ALU: registered result; logical ops keep the stale upper byte.
  always @(posedge clk) begin
    case (alu_inst[18:16])
      3'd0:    alu_r <= {8'h00, alu_inst[15:8]} + {8'h00, alu_inst[7:0]};
      3'd1:    alu_r <= {8'h00, alu_inst[15:8]} - {8'h00, alu_inst[7:0]};
      3'd2:    alu_r <= {8'h00, alu_inst[15:8]} * {8'h00, alu_inst[7:0]};
      3'd3:    alu_r <= {alu_r[15:8], alu_inst[15:8] & alu_inst[7:0]};
      3'd4:    alu_r <= {alu_r[15:8], alu_inst[15:8] | alu_inst[7:0]};
      default: alu_r <= 16'hDEAD;
    endcase
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic logic [15:0] ref_result(input logic [18:0] inst);
    logic [15:0] a;
    logic [15:0] b;
    a = {8'h00, inst[15:8]};
    b = {8'h00, inst[7:0]};
    case (inst[18:16])
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      default: return 16'h0000;
    endcase
  endfunction

  logic        m_busy  = 1'b0;
  int          m_left  = 0;   // cycles until the response becomes visible
  logic        m_owner = 1'b0;
  logic        m_prio  = 1'b0;
  logic [15:0] m_data  = 16'h0;
  logic        m_err   = 1'b0;
  int          m_done  = 0;
  logic [18:0] m_alu   = 19'h0;
  logic        m_g;
  logic [18:0] m_inst;
  logic        m_legal;
  logic [1:0]  exp_rr;
  logic [1:0]  exp_rv;

  assign m_g     = (req_valid == 2'b11) ? m_prio : req_valid[1];
  assign m_inst  = m_g ? req_inst1 : req_inst0;
  assign m_legal = (m_inst[18:16] <= 3'd4);
  assign exp_rr  = (!rst_n || m_busy || req_valid == 2'b00) ? 2'b00
                 : (m_g ? 2'b10 : 2'b01);
  assign exp_rv  = (m_busy && m_left == 0) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_left <= 0;
      m_prio <= 1'b0;
      m_done <= 0;
      m_alu  <= 19'h0;
    end else if (!m_busy) begin
      if (req_valid != 2'b00) begin
        m_busy  <= 1'b1;
        m_owner <= m_g;
        m_prio  <= ~m_g;
        m_left  <= m_legal ? 2 : 0;
        m_data  <= ref_result(m_inst);
        m_err   <= ~m_legal;
        if (m_legal) m_alu <= m_inst;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
    end else if (rsp_ready[m_owner]) begin
      m_busy <= 1'b0;
      m_done <= (m_done + 1) % (1 << CW);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("req_ready", 32'(req_ready), 32'(exp_rr));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      check("ops_done", 32'(ops_done), 32'(m_done));
      check("alu_inst", 32'(alu_inst), 32'(m_alu));
      if (exp_rv != 2'b00) begin
        check("rsp_data", 32'(rsp_data), 32'(m_data));
        check("rsp_err", 32'(rsp_err), 32'(m_err));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int p, input logic [18:0] inst);
    int ok;
    ok = 0;
    if (p == 0) req_inst0 = inst; else req_inst1 = inst;
    req_valid[p] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        ok = 1;
        break;
      end
    end
    check("accept", 32'(ok), 32'd1);
    tick();
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_rsp(input int p, output int lat);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (rsp_valid[p]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic op(input string nm, input int p, input logic [18:0] inst,
                    input logic [15:0] exp_d, input logic exp_e, input int exp_lat);
    int lat;
    issue(p, inst);
    wait_rsp(p, lat);
    check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    check({nm, "_data"}, 32'(rsp_data), 32'(exp_d));
    check({nm, "_err"}, 32'(rsp_err), 32'(exp_e));
    tick();
  endtask

  int          got_port[$];
  logic [15:0] got_data[$];

  task automatic collect(input int n);
    logic [1:0] drop;
    got_port.delete();
    got_data.delete();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      drop = req_ready & req_valid;
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        got_port.push_back(rsp_valid[1] ? 1 : 0);
        got_data.push_back(rsp_data);
      end
      tick();
      req_valid = req_valid & ~drop;
      if (got_port.size() == n) break;
    end
    check("collect_count", 32'(got_port.size()), 32'(n));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int lat;
    logic [15:0] held;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_inst0 = '0;
    req_inst1 = '0;
    rsp_ready = 2'b00;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_alu_inst", 32'(alu_inst), 32'd0);
    check("rst_ops_done", 32'(ops_done), 32'd0);
    tick();
    rst_n     = 1'b1;
    rsp_ready = 2'b11;

    // Single ADD on port 0.
    op("add", 0, {3'd0, 8'hF0, 8'h20}, 16'h0110, 1'b0, 3);
    check("add_ops_done", 32'(ops_done), 32'd1);

    // MUL then AND on port 1; AND must mask the stale upper byte.
    op("mul", 1, {3'd2, 8'hFF, 8'hFF}, 16'hFE01, 1'b0, 3);
    op("and", 1, {3'd3, 8'h0F, 8'hFF}, 16'h000F, 1'b0, 3);

    // Illegal opcode: fast error response, ALU instruction untouched.
    op("illegal", 0, {3'd7, 8'h12, 8'h34}, 16'h0000, 1'b1, 1);
    check("illegal_alu_inst", 32'(alu_inst), 32'({3'd3, 8'h0F, 8'hFF}));

    // Response back-pressure while port 1 waits.
    rsp_ready = 2'b10;
    issue(0, {3'd0, 8'h10, 8'h20});
    req_inst1    = {3'd4, 8'h0F, 8'hF0};
    req_valid[1] = 1'b1;
    wait_rsp(0, lat);
    check("stall_lat", 32'(lat), 32'd3);
    held = rsp_data;
    check("stall_data", 32'(held), 32'h0030);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_data_hold", 32'(rsp_data), 32'h0030);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    tick();
    rsp_ready = 2'b11;
    @(negedge clk);
    check("stall_release_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("stall_p1_accept", 32'(req_ready), 32'd2);
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(1, lat);
    check("or_lat", 32'(lat), 32'd3);
    check("or_data", 32'(rsp_data), 32'h00FF);
    tick();

    // Reset during CAPT drops the operation.
    issue(0, {3'd2, 8'h10, 8'h10});
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("capt_rst_busy", 32'(busy), 32'd0);
    check("capt_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("capt_rst_rsp_data", 32'(rsp_data), 32'd0);
    check("capt_rst_rsp_err", 32'(rsp_err), 32'd0);
    check("capt_rst_alu_inst", 32'(alu_inst), 32'd0);
    check("capt_rst_ops_done", 32'(ops_done), 32'd0);
    check("capt_rst_req_ready", 32'(req_ready), 32'd0);

    // Both ports valid on the first cycle after reset.
    tick();
    req_inst0 = {3'd0, 8'h01, 8'h01};
    req_inst1 = {3'd1, 8'h05, 8'h03};
    req_valid = 2'b11;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("pair_first_grant", 32'(req_ready), 32'd1);
    collect(2);
    if (got_port.size() == 2) begin
      check("pair1_port_a", 32'(got_port[0]), 32'd0);
      check("pair1_data_a", 32'(got_data[0]), 32'h0002);
      check("pair1_port_b", 32'(got_port[1]), 32'd1);
      check("pair1_data_b", 32'(got_data[1]), 32'h0002);
    end
    req_inst0 = {3'd0, 8'h7F, 8'h01};
    req_inst1 = {3'd1, 8'h03, 8'h05};
    req_valid = 2'b11;
    collect(2);
    if (got_port.size() == 2) begin
      check("pair2_port_a", 32'(got_port[0]), 32'd0);
      check("pair2_data_a", 32'(got_data[0]), 32'h0080);
      check("pair2_port_b", 32'(got_port[1]), 32'd1);
      check("pair2_data_b", 32'(got_data[1]), 32'hFFFE);
    end
    req_inst0 = {3'd3, 8'hAA, 8'h0F};
    req_inst1 = {3'd4, 8'h01, 8'h02};
    req_valid = 2'b11;
    collect(2);
    if (got_port.size() == 2) begin
      check("pair3_port_a", 32'(got_port[0]), 32'd0);
      check("pair3_data_a", 32'(got_data[0]), 32'h000A);
    end

    // Counter wrap: six ops since reset, nine more reach 15, one more wraps.
    for (int i = 0; i < 9; i++) begin
      logic [18:0] inst;
      inst = {3'(i % 8), 8'(i * 17), 8'(200 - i * 9)};
      issue(i % 2, inst);
      wait_rsp(i % 2, lat);
      check("loop_lat", 32'(lat), (inst[18:16] > 3'd4) ? 32'd1 : 32'd3);
      tick();
    end
    check("ops_done_max", 32'(ops_done), 32'd15);
    op("wrap", 1, {3'd2, 8'h10, 8'h0F}, 16'h00F0, 1'b0, 3);
    check("ops_done_wrap", 32'(ops_done), 32'd0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port request arbiter and sequencer for the shared 8-bit ALU. Accepts 19-bit ALU instructions from two requesters over valid/ready handshakes and grants them round-robin. It drives one instruction at a time into the ALU, captures the registered 16-bit result, sanitises it per opcode, and returns it to the owning requester over a response handshake. It sits between the instruction-issue logic and the ALU instance.

## Interface
Parameters:
- `CNT_W`, 16: width of the completed-operation counter.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 2: per-port request valid.
- `req_ready` out 2: per-port request accept.
- `req_inst0` in 19: port 0 instruction. Bits [18:16] are the opcode, [15:8] op1, [7:0] op2.
- `req_inst1` in 19: port 1 instruction, same format.
- `rsp_valid` out 2: per-port response valid; at most one bit set.
- `rsp_ready` in 2: per-port response accept.
- `rsp_data` out 16: result, shared by both ports.
- `rsp_err` out 1: illegal opcode flag, shared.
- `alu_inst` out 19: instruction to the ALU.
- `alu_r` in 16: registered ALU result.
- `busy` out 1: high in any state other than IDLE.
- `ops_done` out CNT_W: count of completed responses.

## Operation
Opcodes:
- 000 ADD.
- 001 SUB.
- 010 MUL.
- 011 AND.
- 100 OR.
- 101, 110, 111 are illegal.

State machine:
- IDLE: arbitrate.
  - If one port is valid, that port is granted.
  - If both are valid, port `prio` is granted.
  - `req_ready[g]` = `req_valid[g]`, combinational, in IDLE only.
  - On handshake: latch the instruction, owner `g`, and `prio <= ~g`.
  - Legal opcode → EXEC. Illegal opcode → RESP with `rsp_err=1`, `rsp_data=0`; the ALU is not used.
- EXEC: `alu_inst` holds the latched instruction; the ALU samples it at the end of this cycle. → CAPT.
- CAPT: latch the result register from `alu_r`, sanitised:
  - ADD, SUB, MUL: pass all 16 bits.
  - AND, OR: [15:8] forced to 0, because the ALU leaves stale upper bits for these opcodes.
  - Then → RESP.
- RESP: `rsp_valid[owner]=1`, and `rsp_data`/`rsp_err` are held stable.
  - On `rsp_ready[owner]`: `ops_done++` (wraps at 2^CNT_W−1 → 0), → IDLE.
  - `rsp_ready` on the non-owner port is ignored.

Additional rules:
- `req_valid` is ignored outside IDLE; no request is accepted while busy.
- `alu_inst` holds its last value outside EXEC.
- `rsp_err=0` for all legal opcodes.
- Reset mid-operation drops the in-flight transaction with no response.

## Timing
Reset values:
- State = IDLE, `prio` = 0.
- `req_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0.
- `alu_inst` = 0, `busy` = 0, `ops_done` = 0.

Latency:
- Legal op: handshake in cycle N → EXEC in N+1 → CAPT in N+2 → `rsp_valid` in N+3.
- Illegal op: `rsp_valid` in N+1.
- Back-to-back: the earliest next accept is the cycle after the RESP handshake. Throughput is at most one op per 4 cycles.

Simultaneous requests alternate strictly. A port that keeps `req_valid` high cannot be starved.

## Structure
- Shared package holds:
  - opcode constants `OP_ADD`..`OP_OR`;
  - state encoding `IDLE`/`EXEC`/`CAPT`/`RESP`;
  - instruction field positions `OPC_HI=18`, `OPC_LO=16`, `OP1_HI=15`, `OP1_LO=8`, `OP2_HI=7`, `OP2_LO=0`.
- One sub-module, `rr_arb2`, holds the 2-way round-robin grant logic and the `prio` register (update enabled on accept).
- The ALU is not instantiated inside this block; it connects externally through `alu_inst`/`alu_r`.

## Test plan
- Port 0 sends opcode 000, op1 0xF0, op2 0x20, with `rsp_ready` held high → `rsp_valid[0]` 3 cycles after the accept, `rsp_data`=0x0110, `rsp_err`=0, `ops_done`=1.
- Port 1 sends MUL 0xFF×0xFF, then AND 0x0F&0xFF → responses 0xFE01, then 0x000F (upper byte masked despite the stale 0xFE).
- Both ports valid on the first cycle after reset (port 0 ADD 1+1, port 1 SUB 5−3) → port 0 granted first with 0x0002, then port 1 with 0x0002. A third simultaneous pair is granted port 0 first again.
- Port 0 sends opcode 111 → `rsp_valid[0]` 1 cycle after the accept, `rsp_err`=1, `rsp_data`=0, `alu_inst` unchanged.
- Hold `rsp_ready` low for 5 cycles while port 1 is valid → `rsp_data` stable, `req_ready`=0 throughout. After `rsp_ready`, port 1 is accepted on the next cycle.
- Pull `rst_n` low during CAPT → next cycle all outputs are at reset values and no `rsp_valid` is issued. Also preload `ops_done`=0xFFFF; one more completion → 0x0000.
